present_round_ctrl: RTL

Iterative PRESENT block-cipher encryption engine. It owns the 64-bit cipher state register, the key register and the round counter, and sequences the addRoundKey → sLayer → pLayer datapath once per cycle for 31 rounds, then applies the final whitening key. It is the sequencer around the existing permutation layer and sits between the host-side valid/ready plaintext source and the ciphertext consumer.

---
 rtl/present_round_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/present_round_ctrl.sv
// Iterative PRESENT encryption engine: one round per cycle for ROUNDS rounds, then the final whitening key.
// Build option: define PRESENT_KEY128_EN for the 128-bit key schedule (80-bit key otherwise).
module present_round_ctrl #(
  parameter int BLOCK_W = 64,
  parameter int ROUNDS  = 31,
`ifdef PRESENT_KEY128_EN
  localparam int KEY_W  = 128
`else
  localparam int KEY_W  = 80
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] plaintext,
  input  logic [KEY_W-1:0]   key_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] ciphertext,
  output logic               busy,
  output logic [1:0]         dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // ready/valid outputs depend only on the registered FSM state.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] blk_q, blk_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [4:0]         rnd_q, rnd_d;
  logic [BLOCK_W-1:0] round_key;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  function automatic logic [BLOCK_W-1:0] s_layer(input logic [BLOCK_W-1:0] x);
    s_layer = '0;
    for (int n = 0; n < BLOCK_W / 4; n++) begin
      s_layer[4*n +: 4] = sbox(x[4*n +: 4]);
    end
  endfunction

  // Bit i lands at 16*i mod 63; the top bit is a fixed point.
  function automatic logic [BLOCK_W-1:0] p_layer(input logic [BLOCK_W-1:0] x);
    p_layer = '0;
    for (int i = 0; i < BLOCK_W - 1; i++) begin
      p_layer[(16 * i) % (BLOCK_W - 1)] = x[i];
    end
    p_layer[BLOCK_W-1] = x[BLOCK_W-1];
  endfunction

  function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] k,
                                                  input logic [4:0]       rnd);
    logic [KEY_W-1:0] r;
    r = {k[KEY_W-62:0], k[KEY_W-1:KEY_W-61]};
`ifdef PRESENT_KEY128_EN
    r[127:124] = sbox(r[127:124]);
    r[123:120] = sbox(r[123:120]);
    r[66:62]   = r[66:62] ^ rnd;
`else
    r[79:76]   = sbox(r[79:76]);
    r[19:15]   = r[19:15] ^ rnd;
`endif
    key_update = r;
  endfunction

  assign round_key = key_q[KEY_W-1 -: BLOCK_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      blk_q   <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          blk_d   = plaintext;
          key_d   = key_in;
          rnd_d   = 5'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        blk_d = p_layer(s_layer(blk_q ^ round_key));
        key_d = key_update(key_q, rnd_q);
        // The counter saturates at the last round instead of wrapping to 0.
        if (rnd_q == LAST_ROUND) begin
          state_d = DONE;
        end else begin
          rnd_d = rnd_q + 5'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q == RUN);
  assign out_valid   = (state_q == DONE);
  assign ciphertext  = out_valid ? (blk_q ^ round_key) : '0;
  assign dbg_state_o = state_q;

endmodule
